bit_serializer: RTL and testbench

//   Parallel-to-serial stage feeding the sequence detector's w input, one bit per clock.

---
 rtl/bit_serializer.sv | 144 ++++++++++++++
 tb/tb_bit_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: captures a parallel word on start and shifts it out one bit
// per clock to the sequence detector's w input, optionally repeating the word.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 3,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             w_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   hold;
    logic [CNT_W-1:0]   cnt;
    logic               send_bit;
    logic               last_bit;

    assign last_bit = (cnt == LAST);
    assign send_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; abort wins over start and repeat_en
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (last_bit && !repeat_en) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE: begin
                    state_nx = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Word capture, shifting toward the send end, and bit counting
    always_ff @(posedge clock) begin
        if (!resetn) begin
            shreg <= '0;
            hold  <= '0;
            cnt   <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg <= data_in;
                        hold  <= data_in;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (!last_bit) begin
                        if (MSB_FIRST) begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg <= {1'b0, shreg[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                    end else if (repeat_en) begin
                        shreg <= hold;
                        cnt   <= '0;
                    end
                end
                S_DONE: begin
                    cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Status and serial output decoded from registered state only
    always_comb begin
        w_out     = IDLE_LEVEL;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        bit_idx   = '0;
        unique case (state)
            S_IDLE: begin
                w_out = IDLE_LEVEL;
            end
            S_SHIFT: begin
                w_out     = send_bit;
                bit_valid = 1'b1;
                busy      = 1'b1;
                bit_idx   = cnt;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                w_out = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench; stimulus queues expected serial bits
// and done pulses, negedge monitors pop and compare them.
module tb_bit_serializer;

    typedef struct {
        logic       w;
        logic [2:0] idx;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       abort;
    logic       repeat_en;

    logic       start1;
    logic [7:0] data1;
    logic       w1, bv1, busy1, done1;
    logic [2:0] idx1;

    logic       start2;
    logic [7:0] data2;
    logic       w2, bv2, busy2, done2;
    logic [2:0] idx2;

    exp_t q1[$];
    exp_t q2[$];
    int   dq1;
    int   dq2;
    int   n_cmp;
    int   n_bad;

    bit_serializer #(
        .WIDTH(8), .CNT_W(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
    ) dut_msb (
        .clock(clock), .resetn(resetn), .start(start1), .abort(abort),
        .repeat_en(repeat_en), .data_in(data1), .w_out(w1),
        .bit_valid(bv1), .busy(busy1), .done(done1), .bit_idx(idx1)
    );

    bit_serializer #(
        .WIDTH(8), .CNT_W(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
    ) dut_lsb (
        .clock(clock), .resetn(resetn), .start(start2), .abort(abort),
        .repeat_en(repeat_en), .data_in(data2), .w_out(w2),
        .bit_valid(bv2), .busy(busy2), .done(done2), .bit_idx(idx2)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Queue the expected bit stream of nbits for a word (wraps every 8 bits)
    task automatic push_word(input logic [7:0] d, input bit msb,
                             input int nbits, input bit sel);
        exp_t e;
        logic [7:0] v;
        v = d;
        for (int k = 0; k < nbits; k++) begin
            e.idx = 3'(k % 8);
            e.w   = msb ? v[7 - (k % 8)] : v[k % 8];
            if (sel) q2.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Monitor for the MSB-first instance
    always @(negedge clock) begin
        exp_t e;
        if (bv1) begin
            if (q1.size() == 0) begin
                chk("msb unexpected bit", 32'(idx1), 32'hFFFF);
            end else begin
                e = q1.pop_front();
                chk("msb w_out", 32'(w1), 32'(e.w));
                chk("msb bit_idx", 32'(idx1), 32'(e.idx));
            end
        end
        if (done1) begin
            if (dq1 == 0) chk("msb unexpected done", 32'(done1), 32'd0);
            else dq1--;
        end
    end

    // Monitor for the LSB-first instance
    always @(negedge clock) begin
        exp_t e;
        if (bv2) begin
            if (q2.size() == 0) begin
                chk("lsb unexpected bit", 32'(idx2), 32'hFFFF);
            end else begin
                e = q2.pop_front();
                chk("lsb w_out", 32'(w2), 32'(e.w));
                chk("lsb bit_idx", 32'(idx2), 32'(e.idx));
            end
        end
        if (done2) begin
            if (dq2 == 0) chk("lsb unexpected done", 32'(done2), 32'd0);
            else dq2--;
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        dq1 = 0;
        dq2 = 0;
        resetn = 1'b0;
        abort = 1'b0;
        repeat_en = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;
        step();
        step();
        chk("reset w_out", 32'(w1), 32'd0);
        chk("reset bit_valid", 32'(bv1), 32'd0);
        chk("reset busy", 32'(busy1), 32'd0);
        chk("reset done", 32'(done1), 32'd0);
        chk("reset bit_idx", 32'(idx1), 32'd0);
        resetn = 1'b1;
        step();

        // 1: single MSB-first word
        data1 = 8'b1101_0000;
        push_word(data1, 1'b1, 8, 1'b0);
        dq1 = 1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        data1 = 8'h5A;
        chk("t1 busy E0", 32'(busy1), 32'd1);
        repeat (7) step();
        chk("t1 done before E8", 32'(done1), 32'd0);
        step();
        chk("t1 done after E8", 32'(done1), 32'd1);
        chk("t1 busy in done", 32'(busy1), 32'd1);
        chk("t1 w_out in done", 32'(w1), 32'd0);
        step();
        chk("t1 done after E9", 32'(done1), 32'd0);
        chk("t1 busy after E9", 32'(busy1), 32'd0);
        step();

        // 2: repeated word, repeat_en held 20 cycles
        data1 = 8'b1101_0000;
        push_word(data1, 1'b1, 24, 1'b0);
        dq1 = 1;
        repeat_en = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        data1 = 8'hFF;
        repeat (19) step();
        repeat_en = 1'b0;
        repeat (4) step();
        chk("t2 done before E24", 32'(done1), 32'd0);
        chk("t2 idx at E23", 32'(idx1), 32'd7);
        step();
        chk("t2 done after E24", 32'(done1), 32'd1);
        step();
        chk("t2 busy after E25", 32'(busy1), 32'd0);

        // 3: LSB-first 0x0B sends 1,1,0,1,0,0,0,0
        data2 = 8'h0B;
        push_word(data2, 1'b0, 8, 1'b1);
        dq2 = 1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        data2 = 8'h00;
        repeat (8) step();
        chk("t3 lsb done", 32'(done2), 32'd1);
        step();
        chk("t3 lsb busy", 32'(busy2), 32'd0);

        // 4: start during SHIFT is ignored
        data1 = 8'b1101_0000;
        push_word(data1, 1'b1, 8, 1'b0);
        dq1 = 1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (3) step();
        chk("t4 idx before restart", 32'(idx1), 32'd3);
        data1 = 8'hFF;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (4) step();
        chk("t4 done", 32'(done1), 32'd1);
        step();
        chk("t4 busy low", 32'(busy1), 32'd0);
        repeat (3) step();
        chk("t4 still idle", 32'(busy1), 32'd0);

        // 5: abort at bit 5, then start+abort in IDLE
        data1 = 8'hB5;
        push_word(data1, 1'b1, 6, 1'b0);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (5) step();
        chk("t5 idx before abort", 32'(idx1), 32'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5 busy", 32'(busy1), 32'd0);
        chk("t5 bit_valid", 32'(bv1), 32'd0);
        chk("t5 w_out", 32'(w1), 32'd0);
        chk("t5 done", 32'(done1), 32'd0);
        repeat (3) step();
        start1 = 1'b1;
        abort = 1'b1;
        step();
        start1 = 1'b0;
        abort = 1'b0;
        chk("t5 start+abort busy", 32'(busy1), 32'd0);
        step();
        chk("t5 start+abort stays", 32'(bv1), 32'd0);

        // 6: reset at bit 2, then a fresh full word
        data1 = 8'h96;
        push_word(data1, 1'b1, 3, 1'b0);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (2) step();
        chk("t6 idx before reset", 32'(idx1), 32'd2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("t6 w_out", 32'(w1), 32'd0);
        chk("t6 bit_valid", 32'(bv1), 32'd0);
        chk("t6 busy", 32'(busy1), 32'd0);
        chk("t6 done", 32'(done1), 32'd0);
        chk("t6 bit_idx", 32'(idx1), 32'd0);
        push_word(data1, 1'b1, 8, 1'b0);
        dq1 = 1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (8) step();
        chk("t6 done", 32'(done1), 32'd1);
        repeat (4) step();

        chk("msb bits left", 32'(q1.size()), 32'd0);
        chk("lsb bits left", 32'(q2.size()), 32'd0);
        chk("msb done left", 32'(dq1), 32'd0);
        chk("lsb done left", 32'(dq2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
